bus_controller: RTL

- Central 68000 bus-cycle controller upstream of the DRAM controller.
- Decodes the CPU address into chip selects for ROM, SRAM and I/O, and inserts per-region wait states before asserting DTACK.
- Merges the DRAM controller's DTACK_DRAM into the single CPU DTACK, and runs a bus-error watchdog for unmapped or hung cycles.
- Provides the reset-vector boot overlay: ROM is mirrored at address 0 for the first CPU bus cycles after reset.

---
 rtl/bus_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bus_controller.sv
// 68000 bus-cycle controller: chip-select decode, per-region wait states,
// DTACK merge with the DRAM controller, bus-error watchdog and boot overlay.
module bus_controller #(
  parameter int ROM_WS       = 2,
  parameter int SRAM_WS      = 0,
  parameter int IO_WS        = 4,
  parameter int BERR_TIMEOUT = 64,
  parameter int BOOT_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic [23:0] ADDR_IN,
  input  logic        DTACK_DRAM,
  output logic        CS_ROM,
  output logic        CS_SRAM,
  output logic        CS_IO,
  output logic        DTACK,
  output logic        BERR
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_ACK       = 3'd2;
  localparam logic [2:0] S_EXT       = 3'd3;
  localparam logic [2:0] S_BERR_HOLD = 3'd4;

  localparam int WS_W   = 8;
  localparam int WD_W   = $clog2(BERR_TIMEOUT + 1);
  localparam int BOOT_W = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

  logic [2:0]        state_q, state_d;
  logic              cs_rom_q, cs_rom_d;
  logic              cs_sram_q, cs_sram_d;
  logic              cs_io_q, cs_io_d;
  logic              dtack_q, dtack_d;
  logic              berr_q, berr_d;
  logic [WS_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;

  logic [3:0] addr_hi;
  logic       boot_active;
  logic       sel_low, sel_io, sel_rom_hi;
  logic       wd_expired;
  logic       end_cycle;
  logic       unused_addr;

  assign addr_hi     = ADDR_IN[23:20];
  assign unused_addr = ^ADDR_IN[19:0];
  assign boot_active = (boot_cnt_q < BOOT_W'(BOOT_CYCLES));
  assign sel_low     = (addr_hi == 4'h0);
  assign sel_io      = (addr_hi == 4'hE);
  assign sel_rom_hi  = (addr_hi == 4'hF);

  // Low on either source acknowledges the CPU.
  assign DTACK   = dtack_q & DTACK_DRAM;
  assign CS_ROM  = cs_rom_q;
  assign CS_SRAM = cs_sram_q;
  assign CS_IO   = cs_io_q;
  assign BERR    = berr_q;

  // A simultaneous DTACK keeps the timeout from firing.
  assign wd_expired = (wd_cnt_q >= WD_W'(BERR_TIMEOUT - 1)) && !AS && DTACK;

  always_comb begin
    state_d    = state_q;
    cs_rom_d   = cs_rom_q;
    cs_sram_d  = cs_sram_q;
    cs_io_d    = cs_io_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    wait_cnt_d = wait_cnt_q;
    boot_cnt_d = boot_cnt_q;
    end_cycle  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!AS) begin
          if (sel_rom_hi || (sel_low && boot_active)) begin
            cs_rom_d   = 1'b0;
            wait_cnt_d = WS_W'(ROM_WS);
            state_d    = S_WAIT;
          end else if (sel_low) begin
            cs_sram_d  = 1'b0;
            wait_cnt_d = WS_W'(SRAM_WS);
            state_d    = S_WAIT;
          end else if (sel_io) begin
            cs_io_d    = 1'b0;
            wait_cnt_d = WS_W'(IO_WS);
            state_d    = S_WAIT;
          end else begin
            // DRAM and unmapped space both wait on the external ack or watchdog.
            state_d = S_EXT;
          end
        end
      end
      S_WAIT: begin
        if (AS) begin
          end_cycle = 1'b1;
        end else if (wait_cnt_q == '0) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end else if (wd_expired) begin
          berr_d  = 1'b0;
          state_d = S_BERR_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        if (AS) end_cycle = 1'b1;
      end
      S_EXT: begin
        if (AS) begin
          end_cycle = 1'b1;
        end else if (wd_expired) begin
          berr_d  = 1'b0;
          state_d = S_BERR_HOLD;
        end
      end
      S_BERR_HOLD: begin
        if (AS) end_cycle = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Every finished or aborted cycle counts towards leaving the boot overlay.
    if (end_cycle) begin
      state_d   = S_IDLE;
      cs_rom_d  = 1'b1;
      cs_sram_d = 1'b1;
      cs_io_d   = 1'b1;
      dtack_d   = 1'b1;
      berr_d    = 1'b1;
      if (boot_active) boot_cnt_d = boot_cnt_q + 1'b1;
    end
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (AS) begin
      wd_cnt_d = '0;
    end else if (DTACK && (wd_cnt_q < WD_W'(BERR_TIMEOUT))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cs_rom_q   <= 1'b1;
      cs_sram_q  <= 1'b1;
      cs_io_q    <= 1'b1;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      wait_cnt_q <= '0;
      wd_cnt_q   <= '0;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cs_rom_q   <= cs_rom_d;
      cs_sram_q  <= cs_sram_d;
      cs_io_q    <= cs_io_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      wait_cnt_q <= wait_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

endmodule
